out_port_scheduler: RTL



---
 rtl/out_port_scheduler_pkg.sv | 22 ++
 rtl/out_port_scheduler_if.sv | 30 +++
 rtl/out_port_scheduler_prio_wrr_arbiter.sv | 56 +++++
 rtl/out_port_scheduler.sv | 79 +++++++
 4 files changed

// File: rtl/out_port_scheduler_pkg.sv
// rtl/out_port_scheduler_pkg.sv - types and helpers for the output port scheduler
package out_port_scheduler_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int PRIORITY        = 8;
  localparam int DATA_LENGTH_MAX = 1024;
  localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX);
  localparam int WIDTH_PRIORITY  = $clog2(PRIORITY);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} sched_state_t;

  typedef logic [WIDTH_PRIORITY-1:0]          qsel_t;
  typedef logic [WIDTH_PRIORITY:0]            burst_t;
  typedef logic [WIDTH_LENGTH-1:0]            len_t;
  typedef logic [PRIORITY*WIDTH_LENGTH-1:0]   len_vec_t;
  typedef logic [DATA_WIDTH-1:0]              word_t;

  function automatic len_t head_len(input len_vec_t v, input qsel_t q);
    return v[int'(q)*WIDTH_LENGTH +: WIDTH_LENGTH];
  endfunction

endpackage

// File: rtl/out_port_scheduler_if.sv
// rtl/out_port_scheduler_if.sv - queue status, buffer read and packet output signals of one port
interface out_port_scheduler_if;
  import out_port_scheduler_pkg::*;

  logic [PRIORITY-1:0]  q_nempty;
  len_vec_t             q_head_len;
  logic                 qos_controll;
  logic                 ready;
  logic                 rd_req;
  qsel_t                rd_qsel;
  logic                 q_pop;
  word_t                rd_data_in;
  logic                 rd_sop;
  logic                 rd_eop;
  logic                 rd_vld;
  word_t                rd_data;
  logic                 error;
  logic                 busy;

  modport master (
    input  q_nempty, q_head_len, qos_controll, ready, rd_data_in,
    output rd_req, rd_qsel, q_pop, rd_sop, rd_eop, rd_vld, rd_data, error, busy
  );

  modport slave (
    output q_nempty, q_head_len, qos_controll, ready, rd_data_in,
    input  rd_req, rd_qsel, q_pop, rd_sop, rd_eop, rd_vld, rd_data, error, busy
  );

endinterface

// File: rtl/out_port_scheduler_prio_wrr_arbiter.sv
// rtl/out_port_scheduler_prio_wrr_arbiter.sv - strict / weighted round robin queue select
module prio_wrr_arbiter
  import out_port_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PRIORITY-1:0] q_nempty,
  input  logic                strict,
  input  logic                advance,
  output qsel_t               grant
);

  qsel_t  ptr, ptr_nxt;
  burst_t bc, bc_nxt;

  always_comb begin
    qsel_t idx;
    logic  found;
    grant   = '0;
    ptr_nxt = ptr;
    bc_nxt  = bc;
    idx     = '0;
    found   = 1'b0;
    if (strict) begin
      for (int p = 0; p < PRIORITY; p++)
        if (q_nempty[p]) grant = qsel_t'(p);
    end else if (q_nempty[ptr] && (bc < burst_t'(ptr) + burst_t'(1))) begin
      grant  = ptr;
      bc_nxt = bc + burst_t'(1);
    end else begin
      // Downward search with wrap; the last step revisits ptr itself with a fresh burst.
      for (int i = 1; i <= PRIORITY; i++) begin
        idx = qsel_t'((int'(ptr) + PRIORITY - i) % PRIORITY);
        if (!found && q_nempty[idx]) begin
          found = 1'b1;
          grant = idx;
        end
      end
      if (found) begin
        ptr_nxt = grant;
        bc_nxt  = burst_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= qsel_t'(PRIORITY - 1);
      bc  <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
      bc  <= bc_nxt;
    end
  end

endmodule

// File: rtl/out_port_scheduler.sv
// rtl/out_port_scheduler.sv - per-port packet read sequencer over the priority queues
module out_port_scheduler
  import out_port_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  out_port_scheduler_if.master bus
);

  sched_state_t state, state_nxt;
  qsel_t        grant, qsel_q;
  len_t         grant_len, len_q, cnt_q;
  logic         arb_go, rd_req, last_word;
  logic         err_q, vld_q, sop_q, eop_q;

  assign grant_len = head_len(bus.q_head_len, grant);
  // While the zero-length pop is pending the stale head is still visible, so hold off.
  assign arb_go = (state == IDLE) && (|bus.q_nempty) && !err_q;

  prio_wrr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .q_nempty (bus.q_nempty),
    .strict   (bus.qos_controll),
    .advance  (arb_go),
    .grant    (grant)
  );

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: if (arb_go && (grant_len != '0)) state_nxt = XFER;
      XFER: begin
        rd_req    = bus.ready;
        last_word = rd_req && (cnt_q == len_q - len_t'(1));
        if (last_word) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      qsel_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= arb_go && (grant_len == '0);
      vld_q <= rd_req;
      sop_q <= rd_req && (cnt_q == '0);
      eop_q <= last_word;
      if (arb_go) begin
        qsel_q <= grant;
        len_q  <= grant_len;
        cnt_q  <= '0;
      end else if (rd_req) begin
        cnt_q <= cnt_q + len_t'(1);
      end
    end
  end

  assign bus.rd_req  = rd_req;
  assign bus.rd_qsel = qsel_q;
  assign bus.q_pop   = last_word || err_q;
  assign bus.error   = err_q;
  assign bus.rd_vld  = vld_q;
  assign bus.rd_sop  = sop_q;
  assign bus.rd_eop  = eop_q;
  assign bus.rd_data = bus.rd_data_in;
  assign bus.busy    = (state != IDLE);

endmodule
